// File: rtl/lcd1602_bus_responder.sv
// lcd1602_bus_responder: HD44780/LCD1602 bus-side responder with a 2x16 DDRAM shadow.
// Latency: a bus write executes SYNC_STAGES+1 clk after E falls; rd_data is 1 clk after rd_addr.
// Backpressure: the busy flag (LCD1602_RESPONDER_BUSY_EN) drops writes completed while busy; reads are always served.
//
// Ports: clk/reset (sync, active-low); lcd_rs/lcd_rw/lcd_en/lcd_data_in are the controller-driven
// bus; lcd_data_out/lcd_data_oe are the read-back drive; rd_addr/rd_data read the shadow
// (0-15 line 1, 16-31 line 2); cursor_addr and the display/entry/function flags mirror the
// controller state; busy, char_strobe, cmd_strobe and err_strobe report activity.
// Optional feature: define LCD1602_RESPONDER_BUSY_EN to model the busy window
// (BUSY_CYCLES after writes, CLEAR_BUSY_CYCLES after Clear/Home).
module lcd1602_bus_responder #(
  parameter int SYNC_STAGES       = 2,
  parameter int BUSY_CYCLES       = 2000,
  parameter int CLEAR_BUSY_CYCLES = 80000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       func_8bit,
  output logic       func_2line,
  output logic       busy,
  output logic       char_strobe,
  output logic       cmd_strobe,
  output logic       err_strobe
);

  localparam int CNT_MAX = (BUSY_CYCLES > CLEAR_BUSY_CYCLES) ? BUSY_CYCLES : CLEAR_BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_EXEC, S_BUSY} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] en_sync, rs_sync, rw_sync;
  logic             en_s, rs_s, rw_s;
  logic             en_prev, txn_active, en_rise, en_fall;
  logic             cap_rs, cap_rw;
  logic [7:0]       cap_data;
  logic [7:0]       shadow [32];
  logic [6:0]       ac;
  logic             ac_visible;
  logic [4:0]       ac_idx;
  logic [CNT_W-1:0] busy_cnt;
  logic             instr_wr, data_wr, rd_step, drop_wr;
  logic             cgram_cmd, bad_ddram, clear_home;

  // Address counter step with the two-line wrap: 0x27<->0x40 and 0x67<->0x00.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h40)      return 7'h27;
      else if (a == 7'h00) return 7'h67;
      else                 return a - 7'd1;
    end
  endfunction

  // E resets high so that an E already asserted at release is never seen as a fresh edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_sync <= '1;
      rs_sync <= '0;
      rw_sync <= '0;
    end else begin
      en_sync[0] <= lcd_en;
      rs_sync[0] <= lcd_rs;
      rw_sync[0] <= lcd_rw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        en_sync[i] <= en_sync[i-1];
        rs_sync[i] <= rs_sync[i-1];
        rw_sync[i] <= rw_sync[i-1];
      end
    end
  end

  assign en_s = en_sync[SYNC_STAGES-1];
  assign rs_s = rs_sync[SYNC_STAGES-1];
  assign rw_s = rw_sync[SYNC_STAGES-1];

  // A falling E only counts when its rising edge was seen after reset.
  assign en_rise = en_s & ~en_prev;
  assign en_fall = ~en_s & en_prev & txn_active;

  assign ac_visible  = (ac[5:4] == 2'b00);
  assign ac_idx      = {ac[6], ac[3:0]};
  assign cursor_addr = ac;

  assign cgram_cmd  = (cap_data[7:6] == 2'b01);
  assign bad_ddram  = cap_data[7] && (cap_data[5:0] > 6'h27);
  assign clear_home = (cap_data[7:2] == 6'd0) && (cap_data[1:0] != 2'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (en_fall)                      state_nxt = S_EXEC;
        else if (en_rise || txn_active)   state_nxt = S_CAPTURE;
      end
      S_CAPTURE: if (en_fall) state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_IDLE;
`ifdef LCD1602_RESPONDER_BUSY_EN
        if (!cap_rw) state_nxt = S_BUSY;
`endif
      end
      S_BUSY:  if (busy_cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / action decode
  always_comb begin
    instr_wr    = (state == S_EXEC) && !cap_rw && !cap_rs;
    data_wr     = (state == S_EXEC) && !cap_rw &&  cap_rs;
    // Data reads step AC whether or not the busy window is open.
    rd_step     = cap_rw && cap_rs && ((state == S_EXEC) || ((state == S_BUSY) && en_fall));
    drop_wr     = (state == S_BUSY) && en_fall && !cap_rw;
    cmd_strobe  = instr_wr;
    char_strobe = data_wr && ac_visible;
    err_strobe  = drop_wr || (instr_wr && (cgram_cmd || bad_ddram));
`ifdef LCD1602_RESPONDER_BUSY_EN
    busy        = (state == S_BUSY);
`else
    busy        = 1'b0;
`endif
  end

  // Read-back drive follows the synchronized strobe directly.
  assign lcd_data_oe = en_s & rw_s;
  always_comb begin
    lcd_data_out = 8'h00;
    if (lcd_data_oe) begin
      if (rs_s) lcd_data_out = ac_visible ? shadow[ac_idx] : 8'h20;
      else      lcd_data_out = {busy, ac};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
      ac         <= 7'h00;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      entry_inc  <= 1'b1;
      func_8bit  <= 1'b1;
      func_2line <= 1'b0;
      rd_data    <= 8'h20;
      busy_cnt   <= '0;
      en_prev    <= 1'b1;
      txn_active <= 1'b0;
      cap_rs     <= 1'b0;
      cap_rw     <= 1'b0;
      cap_data   <= 8'h00;
    end else begin
      en_prev <= en_s;
      if (en_rise)      txn_active <= 1'b1;
      else if (en_fall) txn_active <= 1'b0;
      // lcd_data_in is not synchronized: the controller holds it stable while E is high.
      if (en_s) begin
        cap_rs   <= rs_s;
        cap_rw   <= rw_s;
        cap_data <= lcd_data_in;
      end
      rd_data <= shadow[rd_addr];
      if (state == S_BUSY) busy_cnt <= busy_cnt - 1'b1;

      if (data_wr) begin
        if (ac_visible) shadow[ac_idx] <= cap_data;
        ac       <= ac_step(ac, entry_inc);
        busy_cnt <= CNT_W'(BUSY_CYCLES - 1);
      end
      if (rd_step) ac <= ac_step(ac, entry_inc);

      if (instr_wr) begin
        busy_cnt <= clear_home ? CNT_W'(CLEAR_BUSY_CYCLES - 1) : CNT_W'(BUSY_CYCLES - 1);
        casez (cap_data)
          8'b1???????: ac <= bad_ddram ? 7'h00 : cap_data[6:0];
          8'b01??????: ;  // CGRAM not modelled
          8'b001?????: begin
            func_8bit  <= cap_data[4];
            func_2line <= cap_data[3];
          end
          8'b0001????: if (!cap_data[3]) ac <= ac_step(ac, cap_data[2]);
          8'b00001???: begin
            display_on <= cap_data[2];
            cursor_on  <= cap_data[1];
            blink_on   <= cap_data[0];
          end
          8'b000001??: entry_inc <= cap_data[1];
          8'b0000001?: ac <= 7'h00;
          8'b00000001: begin
            for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
            ac        <= 7'h00;
            entry_inc <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd1602_bus_responder.sv
// tb_lcd1602_bus_responder: directed scenarios plus random bus traffic against a reference model.
// Latency: each bus cycle holds E for several clk, then waits for execute and any busy window.
// Backpressure: the busy window is only entered deliberately in the busy-model scenario.
module tb_lcd1602_bus_responder;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, entry_inc, func_8bit, func_2line;
  logic       busy, char_strobe, cmd_strobe, err_strobe;

  lcd1602_bus_responder #(
    .SYNC_STAGES(SYNC), .BUSY_CYCLES(4), .CLEAR_BUSY_CYCLES(40)
  ) dut (
    .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .rd_addr(rd_addr), .rd_data(rd_data), .cursor_addr(cursor_addr),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_inc(entry_inc), .func_8bit(func_8bit), .func_2line(func_2line),
    .busy(busy), .char_strobe(char_strobe), .cmd_strobe(cmd_strobe), .err_strobe(err_strobe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int char_cnt = 0, cmd_cnt = 0, err_cnt = 0;

  always @(posedge clk) begin
    if (char_strobe) char_cnt <= char_cnt + 1;
    if (cmd_strobe)  cmd_cnt  <= cmd_cnt + 1;
    if (err_strobe)  err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mshadow [32];
  logic [6:0] mac;
  bit m_inc, m_disp, m_cur, m_blink, m_8bit, m_2line;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mshadow[i] = 8'h20;
    mac = 7'h00; m_inc = 1; m_disp = 0; m_cur = 0; m_blink = 0; m_8bit = 1; m_2line = 0;
  endfunction

  function automatic bit m_visible(input logic [6:0] a);
    return (a < 7'h10) || (a >= 7'h40 && a < 7'h50);
  endfunction

  function automatic int m_index(input logic [6:0] a);
    return (a < 7'h10) ? int'(a) : 16 + int'(a) - 64;
  endfunction

  // The 80 DDRAM cells form one ring: line 1 is positions 0..39, line 2 is 40..79.
  function automatic logic [6:0] m_move(input logic [6:0] a, input bit up);
    int pos;
    pos = (a >= 7'h40) ? 40 + int'(a) - 64 : int'(a);
    pos = up ? (pos + 1) % 80 : (pos + 79) % 80;
    return (pos >= 40) ? 7'(pos - 40 + 64) : 7'(pos);
  endfunction

  task automatic model_txn(input bit rs, input bit rw, input logic [7:0] d,
                           output int ec, output int ek, output int ee, output logic [7:0] erd);
    logic [6:0] addr;
    ec = 0; ek = 0; ee = 0; erd = 8'h00;
    addr = d[6:0];
    if (rw) begin
      if (rs) begin
        erd = m_visible(mac) ? mshadow[m_index(mac)] : 8'h20;
        mac = m_move(mac, m_inc);
      end else erd = {1'b0, mac};
    end else if (rs) begin
      if (m_visible(mac)) begin mshadow[m_index(mac)] = d; ec = 1; end
      mac = m_move(mac, m_inc);
    end else begin
      ek = 1;
      if (d >= 8'h80) begin
        if ((addr >= 7'h28 && addr <= 7'h3F) || addr >= 7'h68) begin mac = 7'h00; ee = 1; end
        else mac = addr;
      end else if (d >= 8'h40) ee = 1;
      else if (d >= 8'h20) begin m_8bit = d[4]; m_2line = d[3]; end
      else if (d >= 8'h10) begin if (!d[3]) mac = m_move(mac, d[2]); end
      else if (d >= 8'h08) begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
      else if (d >= 8'h04) m_inc = d[1];
      else if (d >= 8'h02) mac = 7'h00;
      else if (d == 8'h01) begin
        for (int i = 0; i < 32; i++) mshadow[i] = 8'h20;
        mac = 7'h00; m_inc = 1;
      end
    end
  endtask

  // ---------------- bus driver ----------------
  task automatic bus_cycle(input bit rs, input bit rw, input logic [7:0] d, input int gap,
                           output logic [7:0] rdv, output logic oe);
    @(negedge clk); lcd_rs = rs; lcd_rw = rw; lcd_data_in = d;
    @(negedge clk); lcd_en = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    rdv = lcd_data_out; oe = lcd_data_oe;
    repeat (2) @(negedge clk);
    lcd_en = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_txn(input bit rs, input bit rw, input logic [7:0] d);
    int c0, k0, e0, ec, ek, ee, gap;
    logic [7:0] rdv, erd;
    logic oe;
    gap = (!rs && !rw && d != 8'h00 && d < 8'h04) ? 50 : 12;
    c0 = char_cnt; k0 = cmd_cnt; e0 = err_cnt;
    model_txn(rs, rw, d, ec, ek, ee, erd);
    bus_cycle(rs, rw, d, gap, rdv, oe);
    chk("char_strobe", char_cnt - c0, ec);
    chk("cmd_strobe", cmd_cnt - k0, ek);
    chk("err_strobe", err_cnt - e0, ee);
    if (rw) begin
      chk("rd_oe", oe, 1);
      chk("rd_value", rdv, erd);
    end
    chk("cursor_addr", cursor_addr, mac);
    chk("flags", {display_on, cursor_on, blink_on, entry_inc, func_8bit, func_2line},
                 {m_disp, m_cur, m_blink, m_inc, m_8bit, m_2line});
    chk("busy_idle", busy, 0);
  endtask

  task automatic peek(input int idx, output logic [7:0] v);
    @(negedge clk); rd_addr = 5'(idx);
    @(negedge clk); v = rd_data;
  endtask

  task automatic check_shadow();
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      peek(i, v);
      chk("rd_data", v, mshadow[i]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v, rdv;
    logic oe;
    int c0, k0, e0, ec, ek, ee, kind;
    logic [7:0] erd;

    // Reset state
    model_reset();
    repeat (4) @(negedge clk);
    chk("rst_cursor", cursor_addr, 7'h00);
    chk("rst_flags", {display_on, cursor_on, blink_on, entry_inc, func_8bit, func_2line}, 6'b000110);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {char_strobe, cmd_strobe, err_strobe}, 3'b000);
    chk("rst_oe", lcd_data_oe, 0);
    chk("rst_data_out", lcd_data_out, 8'h00);
    chk("rst_rd_data", rd_data, 8'h20);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_shadow();

    // Scenario 2: init sequence then two characters
    do_txn(0, 0, 8'h38); do_txn(0, 0, 8'h06); do_txn(0, 0, 8'h0C); do_txn(0, 0, 8'h01);
    do_txn(1, 0, 8'h48); do_txn(1, 0, 8'h4F);
    chk("s2_2line", func_2line, 1);
    chk("s2_display", display_on, 1);
    peek(0, v); chk("s2_sh0", v, 8'h48);
    peek(1, v); chk("s2_sh1", v, 8'h4F);
    chk("s2_cursor", cursor_addr, 7'h02);

    // Scenario 3: end of visible line 1, then line 2
    do_txn(0, 0, 8'h8F); do_txn(1, 0, 8'h41); do_txn(1, 0, 8'h42);
    peek(15, v); chk("s3_sh15", v, 8'h41);
    chk("s3_cursor", cursor_addr, 7'h11);
    do_txn(0, 0, 8'hC0); do_txn(1, 0, 8'h43);
    peek(16, v); chk("s3_sh16", v, 8'h43);

    // Scenario 4: decrement wrap, then an invalid DDRAM address
    do_txn(0, 0, 8'h04); do_txn(0, 0, 8'h80); do_txn(1, 0, 8'h5A);
    peek(0, v); chk("s4_sh0", v, 8'h5A);
    chk("s4_cursor_wrap", cursor_addr, 7'h67);
    e0 = err_cnt;
    do_txn(0, 0, 8'hE8);
    chk("s4_err", err_cnt - e0, 1);
    chk("s4_cursor_zero", cursor_addr, 7'h00);

    // Scenario 6: data read-back
    do_txn(0, 0, 8'h06); do_txn(0, 0, 8'h80); do_txn(1, 0, 8'h41); do_txn(0, 0, 8'h80);
    bus_cycle(1, 1, 8'h00, 12, rdv, oe);
    model_txn(1, 1, 8'h00, ec, ek, ee, erd);
    chk("s6_oe", oe, 1);
    chk("s6_data", rdv, 8'h41);
    chk("s6_cursor", cursor_addr, 7'h01);

`ifdef LCD1602_RESPONDER_BUSY_EN
    // Scenario 5: write inside the Clear busy window is dropped, reads still answer
    k0 = cmd_cnt;
    model_txn(0, 0, 8'h01, ec, ek, ee, erd);
    bus_cycle(0, 0, 8'h01, 0, rdv, oe);
    chk("s5_cmd", cmd_cnt - k0, 1);
    chk("s5_busy_set", busy, 1);
    c0 = char_cnt; e0 = err_cnt;
    bus_cycle(1, 0, 8'h41, 0, rdv, oe);
    chk("s5_drop_char", char_cnt - c0, 0);
    chk("s5_drop_err", err_cnt - e0, 1);
    bus_cycle(0, 1, 8'h00, 0, rdv, oe);
    chk("s5_rd_busy_bit", rdv[7], 1);
    chk("s5_rd_ac", rdv[6:0], mac);
    repeat (50) @(negedge clk);
    chk("s5_busy_clear", busy, 0);
    check_shadow();
`endif

    // Reset in the middle of a data write with E held high across release
    c0 = char_cnt; k0 = cmd_cnt; e0 = err_cnt;
    @(negedge clk); lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data_in = 8'h55;
    @(negedge clk); lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b0;
    repeat (SYNC + 6) @(negedge clk);
    chk("mid_rst_char", char_cnt - c0, 0);
    chk("mid_rst_cmd", cmd_cnt - k0, 0);
    chk("mid_rst_err", err_cnt - e0, 0);
    chk("mid_rst_cursor", cursor_addr, 7'h00);
    peek(0, v); chk("mid_rst_sh0", v, 8'h20);
    do_txn(1, 0, 8'h66);

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 3)      do_txn(0, 0, 8'($urandom));
      else if (kind <= 7) do_txn(1, 0, 8'($urandom));
      else if (kind == 8) do_txn(1, 1, 8'($urandom));
      else                do_txn(0, 1, 8'($urandom));
      if (n % 50 == 49) check_shadow();
    end
    check_shadow();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd1602_bus_responder.md
LCD1602_BUS_RESPONDER -- requirements
Module: lcd1602_bus_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  - SYNC_STAGES, 2: synchronizer depth for lcd_en, lcd_rs and lcd_rw.
  - BUSY_CYCLES, 2000: clk cycles busy is held after a normal write.
  - CLEAR_BUSY_CYCLES, 80000: clk cycles busy is held after Clear or Home.
REQ-002 Ports, one per line: name, direction, width, meaning.
  - clk, in, 1: clock.
  - reset, in, 1: synchronous, active-low.
  - lcd_rs, in, 1: 0 = instruction, 1 = data.
  - lcd_rw, in, 1: 0 = write, 1 = read.
  - lcd_en, in, 1: HD44780 E strobe, asynchronous to clk.
  - lcd_data_in, in, 8: bus value driven by the controller.
  - lcd_data_out, out, 8: read-back value.
  - lcd_data_oe, out, 1: read-back drive enable.
  - rd_addr, in, 5: shadow-buffer index; 0-15 is line 1, 16-31 is line 2.
  - rd_data, out, 8: shadow character, registered.
  - cursor_addr, out, 7: address counter (AC).
  - display_on, out, 1: display enable flag.
  - cursor_on, out, 1: cursor enable flag.
  - blink_on, out, 1: blink enable flag.
  - entry_inc, out, 1: entry-mode increment flag.
  - func_8bit, out, 1: function-set DL bit.
  - func_2line, out, 1: function-set N bit.
  - busy, out, 1: busy flag.
  - char_strobe, out, 1: 1-cycle pulse when a character is stored.
  - cmd_strobe, out, 1: 1-cycle pulse when an instruction executes.
  - err_strobe, out, 1: 1-cycle pulse on an error.

Function
REQ-003 The block SHALL synchronize lcd_en, lcd_rs and lcd_rw through SYNC_STAGES flops; it SHALL capture rs, rw and lcd_data_in on every cycle where synchronized en is 1.
REQ-004 The FSM SHALL have four states:
  - IDLE: go to CAPTURE when en goes high.
  - CAPTURE: go to EXEC when en goes low.
  - EXEC: one cycle; acts on the last captured values; then goes to BUSY or IDLE.
  - BUSY: go to IDLE when the busy counter reaches 0.
REQ-005 In EXEC, an instruction write (rs=0, rw=0) SHALL be decoded by its highest set bit:
  - 0x01 Clear: fill the shadow with 0x20 in one cycle, AC=0x00, entry_inc=1.
  - 0x02/0x03 Home: AC=0x00.
  - 0x04-0x07 Entry mode: entry_inc=bit1; bit0 is ignored.
  - 0x08-0x0F Display control: display_on=bit2, cursor_on=bit1, blink_on=bit0.
  - 0x10-0x1F Shift: if bit3=0, move AC by one (bit2=1 right); if bit3=1, ignored.
  - 0x20-0x3F Function set: func_8bit=bit4, func_2line=bit3.
  - 0x40-0x7F CGRAM: ignored, err_strobe pulses.
  - 0x80+ Set DDRAM: AC=data[6:0]; addresses 0x28-0x3F and 0x68-0x7F instead set AC=0x00 and pulse err_strobe.
  - cmd_strobe SHALL pulse in EXEC for every instruction write.
REQ-006 Data write (rs=1, rw=0): if AC is in 0x00-0x0F or 0x40-0x4F, the shadow entry {AC[6],AC[3:0]} SHALL be written and char_strobe SHALL pulse; otherwise the write is discarded silently. In both cases AC SHALL step afterwards.
REQ-007 AC stepping: +1 when entry_inc=1, -1 otherwise. It SHALL wrap 0x27->0x40, 0x67->0x00, 0x40->0x27 and 0x00->0x67.
REQ-008 Read cycles: lcd_data_oe = synchronized en AND rw, and lcd_data_out SHALL be valid while lcd_data_oe=1.
  - Instruction read (rs=0): lcd_data_out = {busy, AC}.
  - Data read (rs=1): lcd_data_out = shadow[AC] (0x20 when AC is not visible).
  - AC SHALL step in EXEC after a data read; an instruction read changes nothing.
REQ-009 rd_data SHALL equal shadow[rd_addr] one clk after rd_addr is applied.
REQ-010 A write completed while busy=1 SHALL be dropped and SHALL pulse err_strobe; reads SHALL be honoured while busy.

Reset
REQ-011 While reset=0 at a clk edge the block SHALL set:
  - FSM=IDLE; shadow all 0x20; AC=0x00.
  - display_on=0, cursor_on=0, blink_on=0.
  - entry_inc=1, func_8bit=1, func_2line=0.
  - busy=0; all strobes 0; lcd_data_oe=0; lcd_data_out=0x00; rd_data=0x20.
REQ-012 Reset asserted mid-transaction SHALL abort it with no shadow or flag update; the first falling en after release SHALL be ignored if en was high at release.

Configuration
REQ-013 The macro LCD1602_RESPONDER_BUSY_EN SHALL control the busy model.
  - When defined: after an EXEC write, busy=1 for BUSY_CYCLES, or CLEAR_BUSY_CYCLES for Clear/Home, via the BUSY state; REQ-010 applies.
  - When undefined: busy is tied to 0, the BUSY state is unreachable, and no write is ever dropped.

Verification
REQ-014 Scenario 1: reset -> outputs match REQ-011; rd_addr=0..31 all return 0x20.
REQ-015 Scenario 2: writes 0x38, 0x06, 0x0C, 0x01, then data 0x48 0x4F -> func_2line=1, display_on=1, rd_data[0]=0x48, rd_data[1]=0x4F, cursor_addr=0x02.
REQ-016 Scenario 3: 0x8F then data 0x41, 0x42 -> shadow[15]=0x41, 0x42 discarded, cursor_addr=0x11; then 0xC0, 0x43 -> shadow[16]=0x43.
REQ-017 Scenario 4: 0x04 (decrement), 0x80, data 0x5A -> shadow[0]=0x5A, cursor_addr=0x67; then 0xE8 -> err_strobe, cursor_addr=0x00.
REQ-018 Scenario 5 (BUSY_EN defined, BUSY_CYCLES=4): 0x01 then data 0x41 inside the busy window -> dropped, err_strobe; an instruction read in that window returns bit7=1.
REQ-019 Scenario 6: lcd_en pulse with rw=1, rs=1, AC=0x00 after a write of 0x41 at 0x00 -> lcd_data_out=0x41, lcd_data_oe=1 during en, cursor_addr=0x01 afterwards.
